n8_move_pulser: RTL
===================

# n8_move_pulser

Conditions the raw N8 controller button levels into clean, single-cycle move and action strobes for the player-block position register. Each button is synchronized and debounced. Only one direction is accepted at a time. A held direction produces an initial strobe, then auto-repeats after a delay, so one strobe moves the player exactly one tile. Sits between the N8 controller reader and the player-movement block, driving its `left`, `up`, `down`, `right` and `press_A` inputs.

## Interface
- `DB_TICKS`, 2: consecutive `tick` samples a button level must differ from its debounced state before the debounced state flips.
- `REPEAT_DELAY`, 20: ticks from the first strobe of a held direction to the first repeat strobe.
- `REPEAT_PERIOD`, 6: ticks between subsequent repeat strobes.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; one clock.
- `tick` in 1: one-cycle sample enable (frame rate); paces debounce and repeat counters.
- `btn_left`, `btn_up`, `btn_down`, `btn_right`, `btn_a` in 1 each: raw button levels, active-high, asynchronous to `clk`.
- `left`, `up`, `down`, `right` out 1 each: single-cycle move strobes.
- `press_A` out 1: single-cycle action strobe.
- `dir_active` out 1: high while the FSM is in HOLD_DELAY or HOLD_REPEAT.

## Operation
- **Synchronizer:** two flops per button, clocked every cycle.
- **Debounce (per button):**
  - On `tick`, if the synchronized level equals the debounced state, the counter clears.
  - Otherwise the counter increments. When it reaches `DB_TICKS`, the debounced state flips and the counter clears.
  - Counter width is `$clog2(DB_TICKS+1)`.
  - Non-tick cycles hold all counters.
- **Candidate direction:** valid only when exactly one debounced direction is high. Zero or more than one (chord) means no candidate.
- **FSM states:** IDLE, HOLD_DELAY, HOLD_REPEAT. A latched direction register `dir` and a repeat counter `rcnt` accompany it.
  - **IDLE:** a valid candidate issues a strobe on that direction, latches `dir`, clears `rcnt` and moves to HOLD_DELAY.
  - **HOLD_DELAY:**
    - No candidate → IDLE, no strobe.
    - A different valid candidate → strobe the new direction, relatch `dir`, clear `rcnt`, stay in HOLD_DELAY.
    - Otherwise `rcnt` increments on each `tick`. On the tick where `rcnt == REPEAT_DELAY-1`: strobe `dir`, clear `rcnt`, go to HOLD_REPEAT.
  - **HOLD_REPEAT:**
    - Same release and change rules as HOLD_DELAY (a change returns to HOLD_DELAY).
    - Otherwise, on the tick where `rcnt == REPEAT_PERIOD-1`: strobe `dir`, clear `rcnt`.
- **press_A:** fires on a rising edge of debounced A only; no repeat.
  - If it coincides with a direction strobe, it is held in a pending flag and issued the following cycle.
  - Strobes are therefore mutually exclusive: at most one of the five outputs is high in any cycle.
- **Reset mid-operation:** all synchronizers, debounced states, counters and the pending flag clear; the FSM goes to IDLE. A button still held after reset produces a fresh strobe once debounced.

## Timing
- **Reset values:** all outputs 0; FSM IDLE; `dir_active` 0.
- **Outputs:** all registered. A strobe is high exactly one cycle, asserted the cycle after the debounced state or `rcnt` condition that triggers it.
- **Latency from raw edge to strobe** (with `tick` held at 1): 2 sync cycles + `DB_TICKS` cycles + 1 cycle.
- **Repeat spacing:**
  - First repeat comes `REPEAT_DELAY` ticks after the initial strobe.
  - Subsequent repeats come every `REPEAT_PERIOD` ticks.
  - Each repeat is a one-cycle strobe in the cycle after the counting tick.
- **Release:** no strobe is issued after the debounced release is seen; the FSM returns to IDLE one cycle later.
- **Simultaneous reset and any event:** reset wins.

## Test plan
Bench parameters: `DB_TICKS=2`, `REPEAT_DELAY=4`, `REPEAT_PERIOD=2`, `tick` held at 1.

- **Reset hold:** reset held 3 cycles with `btn_right=1` → all outputs 0 during reset; first `right` strobe lands 5 cycles after reset deasserts.
- **Held direction:** `btn_right` held 20 cycles → `right` strobes at relative cycles 0, 4, 6, 8, … each one cycle wide; no other output high; `dir_active=1` from cycle 1 until 1 cycle after the debounced release.
- **Bounce:** `btn_down` toggles every cycle for 12 cycles, then stays 0 → zero `down` strobes, FSM stays IDLE.
- **Chord:** `btn_left` and `btn_up` rise together and are held → no strobes. When `btn_up` drops, a single `left` strobe follows 5 cycles later, then repeats per the held-direction timing.
- **A with direction:** `btn_a` and `btn_right` rise in the same cycle → `right` strobe in cycle N, `press_A` in cycle N+1. With A held a further 30 cycles, no second `press_A`.
- **Reset mid-repeat:** `reset` pulsed for 1 cycle during HOLD_REPEAT with `btn_right` held → outputs 0 and `dir_active=0` next cycle; the next `right` strobe comes 5 cycles after reset deasserts.

Source files
------------

// File: rtl/n8_move_pulser.sv
// n8_move_pulser
//
// Turns raw N8 controller button levels into clean single-cycle move and
// action strobes for the player-position register. Each button is
// synchronized and debounced. Only one direction is accepted at a time.
// A held direction gives an initial strobe, then auto-repeats after a delay.
//
// Strobe protocol: every output strobe is a one-cycle high pulse with no
// back-pressure. The consumer must act in the cycle it is high. At most one
// of left/up/down/right/press_A is high in any cycle.
//
// Parameters
//   DB_TICKS      consecutive differing tick samples needed to flip a
//                 debounced level
//   REPEAT_DELAY  ticks from the first strobe of a held direction to the
//                 first repeat
//   REPEAT_PERIOD ticks between subsequent repeats
//
// Ports
//   clk                  system clock
//   reset                synchronous, active-high
//   tick                 one-cycle sample enable (frame rate)
//   btn_left/up/down/right/a  raw active-high levels, asynchronous to clk
//   left/up/down/right   single-cycle move strobes (registered)
//   press_A              single-cycle action strobe (registered)
//   dir_active           high while a direction is being held
//   state_dbg            current FSM state (debug observation)

module n8_move_pulser #(
    parameter int DB_TICKS      = 2,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_right,
    input  logic       btn_a,
    output logic       left,
    output logic       up,
    output logic       down,
    output logic       right,
    output logic       press_A,
    output logic       dir_active,
    output logic [1:0] state_dbg
);

    // Debounce counter sizing.
    localparam int DW = $clog2(DB_TICKS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_TICKS - 1);

    // Repeat counter is shared by both hold states, so it is sized for the
    // larger of the two intervals.
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } state_t;

    // Button vector bit order: 0 left, 1 up, 2 down, 3 right, 4 A.
    logic [4:0]         raw;
    logic [4:0]         sync1;
    logic [4:0]         sync2;
    logic [4:0]         db;
    logic [4:0][DW-1:0] cnt;

    logic [3:0]         cand;
    logic               cand_valid;
    logic               fire;
    logic               a_rise;

    state_t             state;
    logic [3:0]         dir;
    logic [RW-1:0]      rcnt;
    logic [3:0]         strobe;
    logic               a_pend;
    logic               db_a_q;

    assign raw = {btn_a, btn_right, btn_down, btn_up, btn_left};

    // Two-flop synchronizer, clocked every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-button debounce. A sample equal to the debounced state clears the
    // counter, so only an unbroken run of DB_TICKS differing samples flips it.
    always_ff @(posedge clk) begin
        if (reset) begin
            db  <= '0;
            cnt <= '0;
        end else if (tick) begin
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end
            end
        end
    end

    // A chord (two or more directions) or no direction gives no candidate.
    assign cand       = db[3:0];
    assign cand_valid = $onehot(cand);
    assign a_rise     = db[4] & ~db_a_q;

    // Whether a direction strobe is issued on this clock edge. When a repeat
    // fires, cand equals dir, so the strobed direction is always cand.
    always_comb begin
        fire = 1'b0;
        case (state)
            IDLE:        fire = cand_valid;
            HOLD_DELAY:  fire = cand_valid && ((cand != dir) || (tick && (rcnt == DELAY_LAST)));
            HOLD_REPEAT: fire = cand_valid && ((cand != dir) || (tick && (rcnt == PERIOD_LAST)));
            default:     fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dir        <= '0;
            rcnt       <= '0;
            strobe     <= '0;
            press_A    <= 1'b0;
            a_pend     <= 1'b0;
            db_a_q     <= 1'b0;
            dir_active <= 1'b0;
        end else begin
            db_a_q     <= db[4];
            strobe     <= fire ? cand : 4'b0000;
            dir_active <= (state != IDLE);

            // An A edge that collides with a direction strobe waits one cycle
            // so the outputs stay mutually exclusive.
            press_A <= (a_rise | a_pend) & ~fire;
            a_pend  <= (a_rise | a_pend) & fire;

            case (state)
                IDLE: begin
                    if (cand_valid) begin
                        dir   <= cand;
                        rcnt  <= '0;
                        state <= HOLD_DELAY;
                    end
                end
                HOLD_DELAY: begin
                    if (!cand_valid) begin
                        state <= IDLE;
                    end else if (cand != dir) begin
                        dir  <= cand;
                        rcnt <= '0;
                    end else if (tick) begin
                        if (rcnt == DELAY_LAST) begin
                            rcnt  <= '0;
                            state <= HOLD_REPEAT;
                        end else begin
                            rcnt <= rcnt + RW'(1);
                        end
                    end
                end
                HOLD_REPEAT: begin
                    if (!cand_valid) begin
                        state <= IDLE;
                    end else if (cand != dir) begin
                        dir   <= cand;
                        rcnt  <= '0;
                        state <= HOLD_DELAY;
                    end else if (tick) begin
                        if (rcnt == PERIOD_LAST) begin
                            rcnt <= '0;
                        end else begin
                            rcnt <= rcnt + RW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign left      = strobe[0];
    assign up        = strobe[1];
    assign down      = strobe[2];
    assign right     = strobe[3];
    assign state_dbg = state;

endmodule
